// File: rtl/memx_arb_ctrl_if.sv
`default_nettype none
// memx_arb_ctrl_if -- requester-side and memory-side handshake bundle of memx_arb_ctrl. Rev 1.0
interface memx_arb_ctrl_if #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [N_PORTS-1:0]                 req_rd_i;
  logic [N_PORTS-1:0]                 req_wr_i;
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [N_PORTS-1:0]                 req_done_o;
  logic [N_PORTS-1:0]                 req_err_o;
  logic [DATA_WIDTH-1:0]              rdata_o;
  logic                               busy_o;
  logic                               mem_req_o;
  logic                               mem_we_o;
  logic [ADDR_WIDTH-1:0]              mem_addr_o;
  logic [DATA_WIDTH-1:0]              mem_wdata_o;
  logic                               mem_busy_i;
  logic [DATA_WIDTH-1:0]              mem_rdata_i;

  modport slave (
    input  req_rd_i, req_wr_i, req_addr_i, req_wdata_i, mem_busy_i, mem_rdata_i,
    output req_done_o, req_err_o, rdata_o, busy_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_rd_i, req_wr_i, req_addr_i, req_wdata_i, mem_busy_i, mem_rdata_i,
    input  req_done_o, req_err_o, rdata_o, busy_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/memx_arb_ctrl.sv
`default_nettype none
// memx_arb_ctrl -- round-robin N-port memory controller with range check and busy timeout. Rev 1.0
module memx_arb_ctrl #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int N_OF_WORDS = 1000,
  parameter int TIMEOUT    = 255
) (
  input  wire            clk_i,
  input  wire            rst_ni,
  memx_arb_ctrl_if.slave bus
);
  localparam int PTR_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TCNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TCNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TO_EN     = (TIMEOUT > 0);
  localparam bit ALL_VALID = (longint'(N_OF_WORDS) >= (longint'(1) << ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ALL_VALID ? '0 : ADDR_WIDTH'(N_OF_WORDS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ_READ   = 3'd1,
    WAIT_READ  = 3'd2,
    REQ_WRITE  = 3'd3,
    WAIT_WRITE = 3'd4,
    RESP       = 3'd5,
    ERR        = 3'd6
  } state_t;

  state_t                state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      owner;
  logic [TCNT_W-1:0]     tcnt;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rdata;

  logic [N_PORTS-1:0]    requesting;
  logic                  found;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W:0]        cand;
  logic [PTR_W-1:0]      next_ptr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_wr;
  logic                  addr_ok;
  logic [N_PORTS-1:0]    owner_dec;

  assign requesting = bus.req_rd_i | bus.req_wr_i;

  // Search starts at rr_ptr; cand never exceeds 2*N_PORTS-2, so one subtract wraps it.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_PORTS)) begin
        cand = cand - (PTR_W+1)'(N_PORTS);
      end
      if (!found && requesting[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  assign next_ptr  = (winner == PTR_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
  assign win_addr  = bus.req_addr_i[winner];
  assign win_wdata = bus.req_wdata_i[winner];
  assign win_wr    = bus.req_wr_i[winner];
  assign addr_ok   = ALL_VALID || (win_addr < ADDR_LIMIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner  <= winner;
            rr_ptr <= next_ptr;
            if (!addr_ok) begin
              state <= ERR;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= win_wr;
              mem_addr  <= win_addr;
              mem_wdata <= win_wdata;
              state     <= win_wr ? REQ_WRITE : REQ_READ;
            end
          end
        end
        REQ_READ: begin
          tcnt  <= '0;
          state <= WAIT_READ;
        end
        REQ_WRITE: begin
          tcnt  <= '0;
          state <= WAIT_WRITE;
        end
        WAIT_READ, WAIT_WRITE: begin
          if (!bus.mem_busy_i) begin
            if (state == WAIT_READ) begin
              rdata <= bus.mem_rdata_i;
            end
            state <= RESP;
          end else if (TO_EN && (tcnt == TCNT_W'(TCNT_LAST))) begin
            state <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    owner_dec        = '0;
    owner_dec[owner] = 1'b1;
  end

  assign bus.req_done_o  = (state == RESP) ? owner_dec : '0;
  assign bus.req_err_o   = (state == ERR)  ? owner_dec : '0;
  assign bus.busy_o      = (state != IDLE);
  assign bus.rdata_o     = rdata;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
endmodule
`default_nettype wire
